score_bcd_display_ctrl: RTL and testbench

//   Converts the 16-bit binary score driven by the score PIO output port into decimal

---
 rtl/score_bcd_display_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_score_bcd_display_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/score_bcd_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : score_bcd_display_ctrl
// Description : Converts the binary score from the score PIO into decimal
//               digits with a sequential shift-add-3 (double-dabble) engine,
//               one bit per clock, and drives five active-low seven-segment
//               displays. Displays change atomically when a conversion
//               commits.
// Ports       : clk            system clock
//               reset_n        asynchronous active-low reset
//               score_in       binary score from the score PIO out_port
//               refresh        1-cycle pulse, forces a reconversion
//               blank_leading  1 = blank leading zero digits (hex0 never)
//               busy           high while a conversion is in progress
//               done           1-cycle pulse when new digits are committed
//               bcd_out        committed digits {d4,d3,d2,d1,d0}
//               hex0..hex4     active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_display_ctrl #(
  parameter int SCORE_W    = 16,
  parameter int NUM_DIGITS = 5   // must be at least 5: hex0..hex4 are fixed ports
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SCORE_W-1:0]      score_in,
  input  logic                    refresh,
  input  logic                    blank_leading,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [6:0]              hex0,
  output logic [6:0]              hex1,
  output logic [6:0]              hex2,
  output logic [6:0]              hex3,
  output logic [6:0]              hex4
);

  localparam int c_CNT_W  = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int c_BCD_W  = 4 * NUM_DIGITS;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCORE_W - 1);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_SHIFT  = 2'd1;
  localparam logic [1:0] c_ST_COMMIT = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [SCORE_W-1:0]  r_snap;
  logic [c_BCD_W-1:0]  r_bcd_acc;
  logic [c_BCD_W-1:0]  w_adj;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [c_BCD_W-1:0]  r_bcd_out;
  logic [SCORE_W-1:0]  r_last_score;
  logic                r_pending;
  logic                w_start;

  // A conversion starts from IDLE on a new score, a refresh now, or a
  // refresh remembered from while the engine was busy.
  assign w_start = (r_state == c_ST_IDLE) &&
                   ((score_in != r_last_score) || refresh || r_pending);

  // Add-3 correction on every BCD nibble before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd_acc[gi*4 +: 4] >= 4'd5) ?
                                (r_bcd_acc[gi*4 +: 4] + 4'd3) :
                                r_bcd_acc[gi*4 +: 4];
    end
  endgenerate

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (w_start) w_state_nxt = c_ST_SHIFT;
      c_ST_SHIFT:  if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_COMMIT;
      c_ST_COMMIT: w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap       <= '0;
      r_bcd_acc    <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bcd_out    <= '0;
      r_last_score <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (refresh && (r_state != c_ST_IDLE)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (w_start) begin
            r_snap    <= score_in;
            r_bcd_acc <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
          end
        end
        c_ST_SHIFT: begin
          // The binary word rotates rather than shifts: after SCORE_W steps
          // it is back to the sampled value, which becomes last_score.
          r_bcd_acc <= {w_adj[c_BCD_W-2:0], r_snap[SCORE_W-1]};
          r_snap    <= {r_snap[SCORE_W-2:0], r_snap[SCORE_W-1]};
          r_cnt     <= r_cnt + 1'b1;
        end
        c_ST_COMMIT: begin
          r_bcd_out    <= r_bcd_acc;
          r_last_score <= r_snap;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  logic [NUM_DIGITS-1:0] w_digit_zero;
  logic [6:0]            w_seg [NUM_DIGITS];

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_seg
      assign w_digit_zero[gi] = (r_bcd_out[gi*4 +: 4] == 4'd0);
      if (gi == 0) begin : g_lsd
        assign w_seg[gi] = seg7(r_bcd_out[3:0]);
      end else begin : g_upper
        // Blank when this digit and every more significant digit is zero.
        logic w_blank;
        assign w_blank   = blank_leading && (&w_digit_zero[NUM_DIGITS-1:gi]);
        assign w_seg[gi] = w_blank ? 7'h7F : seg7(r_bcd_out[gi*4 +: 4]);
      end
    end
  endgenerate

  always_comb begin
    busy    = r_busy;
    done    = r_done;
    bcd_out = r_bcd_out;
    hex0    = w_seg[0];
    hex1    = w_seg[1];
    hex2    = w_seg[2];
    hex3    = w_seg[3];
    hex4    = w_seg[4];
  end

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_bcd_display_ctrl
// Description : Self-checking bench for score_bcd_display_ctrl. A table of
//               scores with hand-computed digits and segment codes, plus
//               directed sequences for mid-conversion changes, refresh and
//               reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_bcd_display_ctrl;

  logic        clk;
  logic        reset_n;
  logic [15:0] score_in;
  logic        refresh;
  logic        blank_leading;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4;

  int n_tests;
  int n_fail;

  score_bcd_display_ctrl #(.SCORE_W(16), .NUM_DIGITS(5)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .score_in      (score_in),
    .refresh       (refresh),
    .blank_leading (blank_leading),
    .busy          (busy),
    .done          (done),
    .bcd_out       (bcd_out),
    .hex0          (hex0),
    .hex1          (hex1),
    .hex2          (hex2),
    .hex3          (hex3),
    .hex4          (hex4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]      score;
    logic             blank;
    logic [19:0]      bcd;
    logic [4:0][6:0]  hexs;   // {hex4,hex3,hex2,hex1,hex0}
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_display(input string tag, input logic [4:0][6:0] exp);
    logic [4:0][6:0] act;
    act = {hex4, hex3, hex2, hex1, hex0};
    for (int i = 0; i < 5; i++)
      check($sformatf("%s hex%0d", tag, i), 32'(act[i]), 32'(exp[i]));
  endtask

  // Counts falling edges until done is seen; -1 if the budget runs out.
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  initial begin
    int cyc;
    n_tests = 0;
    n_fail  = 0;

    vecs[0] = '{16'd12345, 1'b1, 20'h12345, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    vecs[1] = '{16'd65535, 1'b1, 20'h65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[2] = '{16'd0,     1'b0, 20'h00000, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[3] = '{16'd7,     1'b1, 20'h00007, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[4] = '{16'd10009, 1'b1, 20'h10009, {7'h79, 7'h40, 7'h40, 7'h40, 7'h10}};
    vecs[5] = '{16'd908,   1'b0, 20'h00908, {7'h40, 7'h40, 7'h10, 7'h40, 7'h00}};
    vecs[6] = '{16'd9999,  1'b1, 20'h09999, {7'h7F, 7'h10, 7'h10, 7'h10, 7'h10}};

    reset_n       = 1'b0;
    score_in      = 16'd0;
    refresh       = 1'b0;
    blank_leading = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state; score 0 matches last_score so nothing starts.
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd", 32'(bcd_out), 32'h0);
    check_display("reset", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

    // Table-driven conversions: drive at a falling edge, E0 is the next
    // rising edge, digits visible after E17 -> 18th falling edge.
    for (int v = 0; v < 7; v++) begin
      blank_leading = vecs[v].blank;
      score_in      = vecs[v].score;
      @(negedge clk);
      check($sformatf("v%0d busy", v), 32'(busy), 32'd1);
      wait_done(40, cyc);
      check($sformatf("v%0d latency", v), 32'(cyc), 32'd17);
      check($sformatf("v%0d bcd", v), 32'(bcd_out), 32'(vecs[v].bcd));
      check($sformatf("v%0d busy_end", v), 32'(busy), 32'd0);
      check_display($sformatf("v%0d", v), vecs[v].hexs);
      @(negedge clk);
      check($sformatf("v%0d done_width", v), 32'(done), 32'd0);
    end

    // Score changes during SHIFT: first result is the old snapshot,
    // then an immediate restart picks up the new score.
    blank_leading = 1'b1;
    score_in      = 16'd100;
    repeat (5) @(negedge clk);
    score_in = 16'd250;
    check("chg busy", 32'(busy), 32'd1);
    wait_done(40, cyc);
    check("chg first latency", 32'(cyc), 32'd13);
    check("chg first bcd", 32'(bcd_out), 32'h00100);
    check_display("chg first", {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40});
    @(negedge clk);
    check("chg restart busy", 32'(busy), 32'd1);
    wait_done(40, cyc);
    check("chg second latency", 32'(cyc), 32'd17);
    check("chg second bcd", 32'(bcd_out), 32'h00250);
    check_display("chg second", {7'h7F, 7'h7F, 7'h24, 7'h12, 7'h40});

    // Refresh while busy: exactly one extra conversion.
    @(negedge clk);
    score_in = 16'd4000;
    @(negedge clk);
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(40, cyc);
    check("rbusy first latency", 32'(cyc), 32'd16);
    check("rbusy first bcd", 32'(bcd_out), 32'h04000);
    wait_done(40, cyc);
    check("rbusy extra latency", 32'(cyc), 32'd18);
    check("rbusy extra bcd", 32'(bcd_out), 32'h04000);
    check_display("rbusy", {7'h7F, 7'h19, 7'h40, 7'h40, 7'h40});
    wait_done(30, cyc);
    check("rbusy no third", 32'(cyc), 32'hFFFF_FFFF);

    // Refresh in IDLE with unchanged score.
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    wait_done(40, cyc);
    check("ridle latency", 32'(cyc), 32'd17);
    check("ridle bcd", 32'(bcd_out), 32'h04000);

    // Reset mid-SHIFT aborts and clears committed digits.
    @(negedge clk);
    score_in = 16'd4321;
    repeat (6) @(negedge clk);
    check("abort busy before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort bcd", 32'(bcd_out), 32'h0);
    check_display("abort", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    @(negedge clk);
    reset_n = 1'b1;
    wait_done(40, cyc);
    check("post reset latency", 32'(cyc), 32'd18);
    check("post reset bcd", 32'(bcd_out), 32'h04321);
    check_display("post reset", {7'h7F, 7'h19, 7'h30, 7'h24, 7'h79});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
